axi_wr_master_arb_mux: RTL and testbench

//  Parametrised N-master -> 1-slave AXI write-path switch with built-in round-robin arbiter.

---
 rtl/axi_wr_master_arb_mux.sv | 191 +++++++++++++++++++
 tb/tb_axi_wr_master_arb_mux.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_master_arb_mux.sv
// N-master to 1-slave AXI write switch; a round-robin grant is held for AW, all W beats and B, then released.
// s_awvalid follows m_awvalid by 1 cycle; ready/valid pass straight through to the owner only, one idle bubble between owners.
module axi_wr_master_arb_mux #(
  parameter int NUM_MASTERS = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int RESP_WIDTH  = 2
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_awid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          m_awlen,
  input  logic [NUM_MASTERS*3-1:0]          m_awsize,
  input  logic [NUM_MASTERS*2-1:0]          m_awburst,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_wid,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]   m_bid,
  output logic [NUM_MASTERS*RESP_WIDTH-1:0] m_bresp,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [ID_WIDTH-1:0]               s_awid,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic [7:0]                        s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ID_WIDTH-1:0]               s_wid,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_WIDTH-1:0]             s_wstrb,
  output logic                              s_wlast,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic [ID_WIDTH-1:0]               s_bid,
  input  logic [RESP_WIDTH-1:0]             s_bresp,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  output logic [NUM_MASTERS-1:0]            wr_grant,
  output logic                              wlast_err
);

  localparam int GW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    awlen_q, awlen_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic          wlast_err_q, wlast_err_d;

  logic aw_hs, w_hs, b_hs, gen_wlast;
  int   g;

  assign g         = int'(grant_q);
  assign gen_wlast = (beat_cnt_q == awlen_q);
  assign aw_hs     = (state_q == S_ADDR) && m_awvalid[grant_q] && s_awready;
  assign w_hs      = (state_q == S_DATA) && m_wvalid[grant_q] && s_wready;
  assign b_hs      = (state_q == S_RESP) && s_bvalid && m_bready[grant_q];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= GW'(NUM_MASTERS - 1);
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      awlen_q     <= awlen_d;
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  always_comb begin
    int  cand;
    logic found;
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    awlen_d     = awlen_q;
    beat_cnt_d  = beat_cnt_q;
    wlast_err_d = wlast_err_q;
    cand        = 0;
    found       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Scan starts just past the last owner so it has lowest priority.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
          cand = (int'(rr_ptr_q) + k) % NUM_MASTERS;
          if (!found && m_awvalid[cand]) begin
            found   = 1'b1;
            grant_d = GW'(cand);
          end
        end
        if (found) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (aw_hs) begin
          awlen_d    = m_awlen[g*8 +: 8];
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (m_wlast[grant_q] != gen_wlast) wlast_err_d = 1'b1;
          if (gen_wlast) begin
            beat_cnt_d = '0;
            state_d    = S_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      S_RESP: begin
        if (b_hs) begin
          rr_ptr_d = grant_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bid     = '0;
    m_bresp   = '0;
    m_bvalid  = '0;
    s_awid    = '0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_awvalid = 1'b0;
    s_wid     = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    wr_grant  = '0;
    if (state_q != S_IDLE) wr_grant[grant_q] = 1'b1;
    case (state_q)
      S_ADDR: begin
        s_awid     = m_awid[g*ID_WIDTH +: ID_WIDTH];
        s_awaddr   = m_awaddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        s_awlen    = m_awlen[g*8 +: 8];
        s_awsize   = m_awsize[g*3 +: 3];
        s_awburst  = m_awburst[g*2 +: 2];
        s_awvalid  = m_awvalid[grant_q];
        m_awready[grant_q] = s_awready;
      end
      S_DATA: begin
        // Slave sees the beat-count view of WLAST, never the master's own.
        s_wid     = m_wid[g*ID_WIDTH +: ID_WIDTH];
        s_wdata   = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb   = m_wstrb[g*STRB_WIDTH +: STRB_WIDTH];
        s_wlast   = gen_wlast;
        s_wvalid  = m_wvalid[grant_q];
        m_wready[grant_q] = s_wready;
      end
      S_RESP: begin
        m_bid[g*ID_WIDTH +: ID_WIDTH]       = s_bid;
        m_bresp[g*RESP_WIDTH +: RESP_WIDTH] = s_bresp;
        m_bvalid[grant_q] = s_bvalid;
        s_bready          = m_bready[grant_q];
      end
      default: ;
    endcase
  end

  assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_axi_wr_master_arb_mux.sv
// Scoreboarded bench for axi_wr_master_arb_mux: directed transactions push expected AW/W/B; monitors pop on handshakes.
module tb_axi_wr_master_arb_mux;
  localparam int N = 3, DW = 32, AW = 32, IW = 4, SW = 4, RW = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic [N*IW-1:0] m_awid, m_wid, m_bid;
  logic [N*AW-1:0] m_awaddr;
  logic [N*8-1:0]  m_awlen;
  logic [N*3-1:0]  m_awsize;
  logic [N*2-1:0]  m_awburst;
  logic [N-1:0]    m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N*RW-1:0] m_bresp;
  logic [IW-1:0]   s_awid, s_wid, s_bid;
  logic [AW-1:0]   s_awaddr;
  logic [7:0]      s_awlen;
  logic [2:0]      s_awsize;
  logic [1:0]      s_awburst;
  logic            s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [RW-1:0]   s_bresp;
  logic [N-1:0]    wr_grant;
  logic            wlast_err;

  axi_wr_master_arb_mux #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                          .STRB_WIDTH(SW), .RESP_WIDTH(RW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .wr_grant(wr_grant), .wlast_err(wlast_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          aw_m_q[$];
  logic [63:0] aw_p_q[$];
  int          w_m_q[$];
  logic [63:0] w_p_q[$];
  int          b_m_q[$];
  logic [IW-1:0] b_id_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] wd(input int m, input int b);
    return {4'(m), 4'hA, 8'(b), 8'(m * 17), 8'(b * 5)};
  endfunction

  // Expected traffic for one complete transaction, in the order the slave will see it.
  task automatic push_txn(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
    aw_m_q.push_back(m);
    aw_p_q.push_back({15'b0, id, addr, 8'(len), 3'd2, 2'd1});
    for (int b = 0; b <= len; b++) begin
      w_m_q.push_back(m);
      w_p_q.push_back({23'b0, wd(m, b), (b == len), 4'(b + 1), id});
    end
    b_m_q.push_back(m);
    b_id_q.push_back(id);
  endtask

  // sel: 0 = awready, 1 = wready, 2 = bvalid of master m; leaves caller at the negedge it was seen.
  task automatic wait_hs(input int sel, input int m);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge sys_clk);
      if ((sel == 0 && m_awready[m]) || (sel == 1 && m_wready[m]) || (sel == 2 && m_bvalid[m])) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: master %0d channel %0d never became ready, expected within 400 cycles", m, sel);
    end
  endtask

  task automatic master_txn(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input int bad_beat, input int bdelay, input int abort_beat);
    m_awid[m*IW +: IW]   = id;
    m_awaddr[m*AW +: AW] = addr;
    m_awlen[m*8 +: 8]    = 8'(len);
    m_awsize[m*3 +: 3]   = 3'd2;
    m_awburst[m*2 +: 2]  = 2'd1;
    m_awvalid[m]         = 1'b1;
    wait_hs(0, m);
    cyc();
    m_awvalid[m] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      m_wid[m*IW +: IW]   = id;
      m_wdata[m*DW +: DW] = wd(m, b);
      m_wstrb[m*SW +: SW] = 4'(b + 1);
      m_wlast[m]          = (b == bad_beat);
      m_wvalid[m]         = 1'b1;
      if (b == abort_beat) begin
        sys_rst = 1'b1;
        #1;
        check("rst_mid_ctrl_outputs", {s_awvalid, s_wvalid, s_wlast, s_bready, wr_grant, m_awready, m_wready, m_bvalid}, 0);
        check("rst_mid_wdata", s_wdata, 0);
        check("rst_mid_wlast_err", wlast_err, 0);
        cyc();
        sys_rst      = 1'b0;
        m_wvalid[m]  = 1'b0;
        m_wlast[m]   = 1'b0;
        return;
      end
      wait_hs(1, m);
      cyc();
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m]  = 1'b0;
    if (bdelay == 0) m_bready[m] = 1'b1;
    wait_hs(2, m);
    if (bdelay > 0) begin
      for (int k = 0; k < bdelay; k++) begin
        check("b_stall_grant_held", wr_grant, 1 << m);
        check("b_stall_no_awready", {s_awvalid, m_awready}, 0);
        @(negedge sys_clk);
      end
      cyc();
      m_bready[m] = 1'b1;
      @(negedge sys_clk);
    end
    cyc();
    m_bready[m] = 1'b0;
  endtask

  // Slave model: one B per WLAST beat, BID from the last accepted AW, BRESP = BID[1:0].
  initial begin
    logic [IW-1:0] slv_id;
    bit hs_b, hs_wl;
    s_bvalid = 1'b0;
    s_bid    = '0;
    s_bresp  = '0;
    slv_id   = '0;
    forever begin
      @(negedge sys_clk);
      hs_b  = s_bvalid && s_bready;
      hs_wl = s_wvalid && s_wready && s_wlast;
      if (s_awvalid && s_awready) slv_id = s_awid;
      @(posedge sys_clk);
      #1;
      if (hs_b) s_bvalid = 1'b0;
      if (hs_wl) begin
        s_bvalid = 1'b1;
        s_bid    = slv_id;
        s_bresp  = slv_id[1:0];
      end
    end
  end

  // Monitor: pops one expectation per observed handshake.
  initial begin
    int            xm;
    logic [63:0]   xp;
    logic [IW-1:0] xid;
    logic [N*IW-1:0] eb;
    logic [N*RW-1:0] er;
    forever begin
      @(negedge sys_clk);
      if (s_awvalid && s_awready) begin
        if (aw_m_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          xm = aw_m_q.pop_front();
          xp = aw_p_q.pop_front();
          check("aw_grant", wr_grant, 1 << xm);
          check("aw_ready_onehot", m_awready, 1 << xm);
          check("aw_payload", {15'b0, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}, xp);
        end
      end
      if (s_wvalid && s_wready) begin
        if (w_m_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          xm = w_m_q.pop_front();
          xp = w_p_q.pop_front();
          check("w_ready_onehot", m_wready, 1 << xm);
          check("w_payload", {23'b0, s_wdata, s_wlast, s_wstrb, s_wid}, xp);
        end
      end
      if ((m_bvalid & m_bready) != '0) begin
        if (b_m_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          xm  = b_m_q.pop_front();
          xid = b_id_q.pop_front();
          eb  = '0;
          er  = '0;
          eb[xm*IW +: IW] = xid;
          er[xm*RW +: RW] = xid[1:0];
          check("b_valid_onehot", m_bvalid, 1 << xm);
          check("b_payload", {m_bid, m_bresp}, {eb, er});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst   = 1'b1;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
    m_wid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    repeat (2) cyc();
    m_awvalid = '1;
    cyc();
    check("reset_outputs", {s_awvalid, s_wvalid, s_bready, wr_grant, m_awready, m_wready, m_bvalid}, 0);
    check("reset_wlast_err", wlast_err, 0);
    m_awvalid = '0;
    sys_rst   = 1'b0;
    cyc();

    // 1: single m0 burst, AW latency and release of the grant.
    push_txn(0, 4'h3, 32'h0000_1000, 3);
    fork
      master_txn(0, 4'h3, 32'h0000_1000, 3, 3, 0, -1);
      begin
        @(negedge sys_clk);
        check("t1_aw_latency_cycle0", s_awvalid, 0);
        @(negedge sys_clk);
        check("t1_aw_latency_cycle1", {s_awvalid, wr_grant}, {1'b1, 3'b001});
      end
    join
    check("t1_grant_released", wr_grant, 0);

    // 2: simultaneous requests after m0 owned last -> 1,2,0; then {0,2} -> 2,0.
    push_txn(1, 4'h5, 32'h0000_2100, 1);
    push_txn(2, 4'h6, 32'h0000_2200, 2);
    push_txn(0, 4'h7, 32'h0000_2000, 0);
    fork
      master_txn(0, 4'h7, 32'h0000_2000, 0, 0, 0, -1);
      master_txn(1, 4'h5, 32'h0000_2100, 1, 1, 0, -1);
      master_txn(2, 4'h6, 32'h0000_2200, 2, 2, 0, -1);
    join
    push_txn(2, 4'h9, 32'h0000_3200, 0);
    push_txn(0, 4'h8, 32'h0000_3000, 1);
    fork
      master_txn(0, 4'h8, 32'h0000_3000, 1, 1, 0, -1);
      master_txn(2, 4'h9, 32'h0000_3200, 0, 0, 0, -1);
    join

    // 3: m1 awlen=0 with a 5-cycle W stall.
    s_wready = 1'b0;
    push_txn(1, 4'hA, 32'h0000_4100, 0);
    fork
      master_txn(1, 4'hA, 32'h0000_4100, 0, 0, 0, -1);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge sys_clk);
          if (s_wvalid) break;
        end
        for (int k = 0; k < 5; k++) begin
          check("t3_stall_held", {s_wvalid, s_wlast, s_wdata, m_wready}, {1'b1, 1'b1, wd(1, 0), 3'b000});
          if (k < 4) @(negedge sys_clk);
        end
        cyc();
        s_wready = 1'b1;
      end
    join

    // 4: m2 flags WLAST on the wrong beat; error is sticky across a clean burst.
    check("t4_err_clear_before", wlast_err, 0);
    push_txn(2, 4'hB, 32'h0000_5200, 1);
    master_txn(2, 4'hB, 32'h0000_5200, 1, 0, 0, -1);
    check("t4_err_set", wlast_err, 1);
    push_txn(0, 4'hC, 32'h0000_5000, 2);
    master_txn(0, 4'hC, 32'h0000_5000, 2, 2, 0, -1);
    check("t4_err_sticky", wlast_err, 1);

    // 5: reset on beat 3 of m1's awlen=7 burst; rr pointer returns to favour m0.
    aw_m_q.push_back(1);
    aw_p_q.push_back({15'b0, 4'hD, 32'h0000_6100, 8'd7, 3'd2, 2'd1});
    for (int b = 0; b < 2; b++) begin
      w_m_q.push_back(1);
      w_p_q.push_back({23'b0, wd(1, b), 1'b0, 4'(b + 1), 4'hD});
    end
    master_txn(1, 4'hD, 32'h0000_6100, 7, 7, 0, 2);
    check("t5_idle_after_reset", {wr_grant, wlast_err}, 0);
    push_txn(0, 4'h1, 32'h0000_7000, 0);
    push_txn(1, 4'h2, 32'h0000_7100, 0);
    push_txn(2, 4'h3, 32'h0000_7200, 0);
    fork
      master_txn(0, 4'h1, 32'h0000_7000, 0, 0, 0, -1);
      master_txn(1, 4'h2, 32'h0000_7100, 0, 0, 0, -1);
      master_txn(2, 4'h3, 32'h0000_7200, 0, 0, 0, -1);
    join

    // 6: m0 holds B for 10 cycles while m1 waits for the grant.
    push_txn(0, 4'hE, 32'h0000_8000, 3);
    push_txn(1, 4'hF, 32'h0000_8100, 1);
    fork
      master_txn(0, 4'hE, 32'h0000_8000, 3, 3, 10, -1);
      begin
        repeat (3) cyc();
        master_txn(1, 4'hF, 32'h0000_8100, 1, 1, 0, -1);
      end
    join

    repeat (3) cyc();
    check("end_aw_queue_empty", aw_m_q.size(), 0);
    check("end_w_queue_empty", w_m_q.size(), 0);
    check("end_b_queue_empty", b_m_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
